// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller.
// FSM state encoding and the default operand width.
package serial_add_pkg;

  localparam int SA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_e;

endpackage

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller wrapped around an external
// one-bit full-adder cell: start/busy/done, LSB first.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             fa_a_o,
  output logic             fa_b_o,
  output logic             fa_ci_o,
  input  logic             fa_sum_i,
  input  logic             fa_co_i
);

  localparam int CW = $clog2(WIDTH);

  sa_state_e        state_q;
  sa_state_e        state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [CW-1:0]    cnt;
  logic             last;

  assign last    = (cnt == CW'(WIDTH - 1));
  assign sum_nxt = {fa_sum_i, sum_sh[WIDTH-1:1]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = RUN;
      RUN:  if (last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            a_sh    <= a_i;
            b_sh    <= b_i;
            carry_q <= cin_i;
            cnt     <= '0;
            sum_sh  <= '0;
          end
        end
        RUN: begin
          sum_sh  <= sum_nxt;
          carry_q <= fa_co_i;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          cnt     <= cnt + 1'b1;
          // result registers move only on the final bit
          if (last) begin
            sum_q  <= sum_nxt;
            cout_q <= fa_co_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o  = (state_q == RUN);
  assign done_o  = (state_q == DONE);
  assign sum_o   = sum_q;
  assign cout_o  = cout_q;
  assign fa_a_o  = busy_o & a_sh[0];
  assign fa_b_o  = busy_o & b_sh[0];
  assign fa_ci_o = busy_o & carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench: controller plus a behavioural
// one-bit full-adder cell, checked with assertions.
module tb_serial_adder_ctrl;
  import serial_add_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         fa_a;
  logic         fa_b;
  logic         fa_ci;
  logic         fa_sum;
  logic         fa_co;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign fa_sum = fa_a ^ fa_b ^ fa_ci;
  assign fa_co  = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .cin_i   (cin),
    .busy_o  (busy),
    .done_o  (done),
    .sum_o   (sum),
    .cout_o  (cout),
    .fa_a_o  (fa_a),
    .fa_b_o  (fa_b),
    .fa_ci_o (fa_ci),
    .fa_sum_i(fa_sum),
    .fa_co_i (fa_co)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_add(input string tag,
                         input logic [W-1:0] av,
                         input logic [W-1:0] bv,
                         input logic cv,
                         input logic [W-1:0] es,
                         input logic ec);
    int ticks;
    int busy_n;
    a = av;
    b = bv;
    cin = cv;
    start = 1'b1;
    tick();
    start = 1'b0;
    // scramble inputs to prove they were latched
    a = ~av;
    b = ~bv;
    cin = ~cv;
    ticks = 1;
    busy_n = busy ? 1 : 0;
    while (!done && ticks < 20) begin
      tick();
      ticks++;
      if (busy) busy_n++;
    end
    check({tag, " latency"}, ticks, 9);
    check({tag, " busy_cycles"}, busy_n, 8);
    check({tag, " sum"}, 32'(sum), 32'(es));
    check({tag, " cout"}, 32'(cout), 32'(ec));
    tick();
    check({tag, " done_pulse"}, 32'(done), 0);
  endtask

  initial begin
    int n;
    int pulses;
    int first_t;
    int prev_t;
    int bad_gap;
    int viol;

    #12;
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst sum", 32'(sum), 0);
    check("rst cout", 32'(cout), 0);
    check("rst fa", {29'd0, fa_a, fa_b, fa_ci}, 0);
    rst_n = 1'b1;
    tick();
    check("idle busy", 32'(busy), 0);

    run_add("5A+A5", 8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0);
    check("idle fa", {29'd0, fa_a, fa_b, fa_ci}, 0);
    run_add("FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_add("FF+FF+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // start pulse during RUN must be ignored
    a = 8'h10;
    b = 8'h20;
    cin = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("ign sum_hold", 32'(sum), 32'hFF);
    a = 8'h01;
    b = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("ign done_seen", 32'(done), 1);
    check("ign sum", 32'(sum), 32'h30);
    check("ign cout", 32'(cout), 0);
    pulses = 0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) pulses++;
      if (busy) n++;
    end
    check("ign extra_done", pulses, 0);
    check("ign extra_busy", n, 0);

    // asynchronous reset in the middle of an add
    a = 8'h12;
    b = 8'h34;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("arst pre_busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst busy", 32'(busy), 0);
    check("arst done", 32'(done), 0);
    check("arst sum", 32'(sum), 0);
    check("arst cout", 32'(cout), 0);
    #3;
    rst_n = 1'b1;
    tick();
    check("arst no_done", 32'(done), 0);
    run_add("03+04", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0);

    // start held high: one completion every 10 cycles
    a = 8'h80;
    b = 8'h80;
    cin = 1'b0;
    start = 1'b1;
    pulses = 0;
    first_t = 0;
    prev_t = 0;
    bad_gap = 0;
    viol = 0;
    for (int t = 1; t <= 35; t++) begin
      tick();
      if (done) begin
        if (pulses == 0) first_t = t;
        else if (t - prev_t != 10) bad_gap++;
        prev_t = t;
        pulses++;
      end
      if (t < 9 && sum !== 8'h07) viol++;
      if (t >= 9 && (sum !== 8'h00 || cout !== 1'b1)) viol++;
    end
    start = 1'b0;
    check("b2b first_done", first_t, 9);
    check("b2b pulses", pulses, 3);
    check("b2b gaps", bad_gap, 0);
    check("b2b sum_stable", viol, 0);
    check("b2b sum", 32'(sum), 0);
    check("b2b cout", 32'(cout), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
